// File: rtl/data_mem_responder.sv
// RAM-side responder for the CPU memory stage: byte/half/word loads and stores
// on a word-organised little-endian array, with wait states and fault reporting.
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_enable,
  input  logic        mem_read_enable,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic        mem_busy
);

  localparam int unsigned DEPTH     = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WOFF_W    = 30;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES - 1);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        uns;
    logic        wr;
    logic        rd;
  } req_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t req_q, req_in, eff;
  logic accept_c, enter_resp_c, fault_c;
  logic [WOFF_W-1:0] word_off_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [31:0] rd_word_c, shifted_c, load_val_c, lane_data_c;
  logic [3:0]  lane_mask_c;

  logic [31:0] mem [DEPTH];

  assign req_in   = {mem_addr, mem_write_data, mem_size, mem_unsigned,
                     mem_write_enable, mem_read_enable};
  assign accept_c = mem_write_enable | mem_read_enable;

  // In IDLE the live request is used so a zero-wait access completes on the accept edge.
  assign eff = (state_q == S_IDLE) ? req_in : req_q;

  assign word_off_c = WOFF_W'((eff.addr - BASE_ADDR) >> 2);
  assign idx_c      = word_off_c[DEPTH_LOG2-1:0];

  assign fault_c = (eff.wr & eff.rd)
                 | (eff.size == SIZE_RSVD)
                 | ((eff.size == SIZE_HALF) & eff.addr[0])
                 | ((eff.size == SIZE_WORD) & (eff.addr[1:0] != 2'b00))
                 | (word_off_c >= WOFF_W'(DEPTH));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; enter_resp_c marks the commit/read edge
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cnt_d = '0;
          if (WAIT_STATES == 0) begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d      = S_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Store lane steering: replicate the right-aligned data across the word
  always_comb begin
    lane_data_c = eff.data;
    lane_mask_c = 4'b1111;
    case (eff.size)
      SIZE_BYTE: begin
        lane_data_c = {4{eff.data[7:0]}};
        lane_mask_c = 4'(4'b0001 << eff.addr[1:0]);
      end
      SIZE_HALF: begin
        lane_data_c = {2{eff.data[15:0]}};
        lane_mask_c = eff.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data_c = eff.data;
        lane_mask_c = 4'b1111;
      end
    endcase
  end

  // Load extraction and sign/zero extension
  always_comb begin
    rd_word_c  = mem[idx_c];
    shifted_c  = rd_word_c >> {eff.addr[1:0], 3'b000};
    load_val_c = rd_word_c;
    case (eff.size)
      SIZE_BYTE: load_val_c = eff.uns ? {24'h0, shifted_c[7:0]}
                                      : {{24{shifted_c[7]}}, shifted_c[7:0]};
      SIZE_HALF: load_val_c = eff.uns ? {16'h0, shifted_c[15:0]}
                                      : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default:   load_val_c = rd_word_c;
    endcase
  end

  // Storage is never cleared; reset on the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && enter_resp_c && eff.wr && !fault_c) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask_c[b]) mem[idx_c][8*b +: 8] <= lane_data_c[8*b +: 8];
      end
    end
  end

  // Request latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      mem_ready     <= 1'b0;
      mem_fault     <= 1'b0;
      mem_busy      <= 1'b0;
      mem_read_data <= '0;
    end else begin
      if (state_q == S_IDLE && accept_c) req_q <= req_in;
      mem_ready <= enter_resp_c;
      mem_fault <= enter_resp_c & fault_c;
      mem_busy  <= (state_d != S_IDLE);
      if (enter_resp_c && eff.rd && !fault_c) mem_read_data <= load_val_c;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a zero-wait instance and a three-wait
// instance share clock, reset and request payload but have separate enables.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        we, re, we3, re3;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] rdata0, rdata3;
  logic        ready0, fault0, busy0;
  logic        ready3, fault3, busy3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_write_data(wdata),
    .mem_write_enable(we), .mem_read_enable(re), .mem_size(size),
    .mem_unsigned(uns), .mem_read_data(rdata0), .mem_ready(ready0),
    .mem_fault(fault0), .mem_busy(busy0)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_write_data(wdata),
    .mem_write_enable(we3), .mem_read_enable(re3), .mem_size(size),
    .mem_unsigned(uns), .mem_read_data(rdata3), .mem_ready(ready3),
    .mem_fault(fault3), .mem_busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request to instance sel, hold it until mem_ready (bounded), return latency
  task automatic req(input int sel, input logic w, input logic r, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] d,
                     output int lat);
    @(posedge clk); #1;
    addr = a; wdata = d; size = sz; uns = u;
    if (sel == 0) begin we = w; re = r; end
    else begin we3 = w; re3 = r; end
    lat = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
    end while (!((sel == 0) ? ready0 : ready3) && lat < 20);
    we = 1'b0; re = 1'b0; we3 = 1'b0; re3 = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    we3 = 1'b0; re3 = 1'b0; size = 2'b10; uns = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready0), 32'h0);
    chk("rst_fault", 32'(fault0), 32'h0);
    chk("rst_busy",  32'(busy0),  32'h0);
    chk("rst_rdata", rdata0,      32'h0);

    // 1: word store then word load, one-cycle latency
    req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat);
    chk("st_word_lat",   32'(lat),    32'd1);
    chk("st_word_fault", 32'(fault0), 32'h0);
    chk("st_word_busy",  32'(busy0),  32'h1);
    chk("st_rdata_hold", rdata0,      32'h0);
    @(negedge clk);
    chk("ready_single",  32'(ready0), 32'h0);
    req(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    chk("ld_word_lat",   32'(lat),    32'd1);
    chk("ld_word_fault", 32'(fault0), 32'h0);
    chk("ld_word_data",  rdata0,      32'hDEADBEEF);

    // 2: byte store into a cleared word, then extended loads
    req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    req(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0000_0080, lat);
    chk("st_byte_fault", 32'(fault0), 32'h0);
    req(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0, lat);
    chk("ld_byte_s", rdata0, 32'hFFFFFF80);
    req(0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h11, 32'h0, lat);
    chk("ld_byte_u", rdata0, 32'h00000080);
    req(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0, lat);
    chk("ld_half_s", rdata0, 32'hFFFF8000);
    req(0, 1'b0, 1'b1, 2'b10, 1'b1, 32'h10, 32'h0, lat);
    chk("ld_word_after_byte", rdata0, 32'h00008000);

    // 3: misaligned accesses fault without side effects
    req(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h0, lat);
    chk("mis_half_ready", 32'(ready0), 32'h1);
    chk("mis_half_fault", 32'(fault0), 32'h1);
    chk("mis_half_rdata", rdata0,      32'h00008000);
    req(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h0, lat);
    chk("mis_word_fault", 32'(fault0), 32'h1);
    chk("mis_word_rdata", rdata0,      32'h00008000);
    req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, lat);
    chk("mis_st_fault",   32'(fault0), 32'h1);
    req(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    chk("mis_st_nowrite", rdata0,      32'h00008000);

    // 4: three wait states, payload changed mid-wait
    req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h12345678, lat);
    chk("ws3_st_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    re3 = 1'b1; addr = 32'h40; size = 2'b10; uns = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ws3_busy",    32'(busy3),  32'h1);
    chk("ws3_ready_1", 32'(ready3), 32'h0);
    addr = 32'h13; size = 2'b01;
    @(negedge clk);
    chk("ws3_ready_2", 32'(ready3), 32'h0);
    @(negedge clk);
    chk("ws3_ready_3", 32'(ready3), 32'h0);
    @(negedge clk);
    chk("ws3_ready_4", 32'(ready3), 32'h1);
    chk("ws3_fault",   32'(fault3), 32'h0);
    chk("ws3_rdata",   rdata3,      32'h12345678);
    re3 = 1'b0;

    // 5: reset on the commit edge abandons the store
    req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, lat);
    @(posedge clk); #1;
    we3 = 1'b1; addr = 32'h20; wdata = 32'h11111111; size = 2'b10;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ready", 32'(ready3), 32'h0);
    chk("rst_mid_fault", 32'(fault3), 32'h0);
    chk("rst_mid_busy",  32'(busy3),  32'h0);
    chk("rst_mid_rdata", rdata3,      32'h0);
    chk("rst_mid_rd0",   rdata0,      32'h0);
    we3 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    req(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat);
    chk("rst_old_data", rdata3, 32'hCAFEF00D);

    // 6: range boundaries and conflicting enables
    req(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    chk("mem_kept_rst", rdata0, 32'h00008000);
    req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0FFC, 32'hA5A5A5A5, lat);
    chk("last_st_fault", 32'(fault0), 32'h0);
    req(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0FFC, 32'h0, lat);
    chk("last_ld_data",  rdata0, 32'hA5A5A5A5);
    req(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h0, lat);
    chk("oor_fault",     32'(fault0), 32'h1);
    chk("oor_rdata",     rdata0,      32'hA5A5A5A5);
    req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h77777777, lat);
    chk("wrap_fault",    32'(fault0), 32'h1);
    req(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h55555555, lat);
    chk("both_en_fault", 32'(fault0), 32'h1);
    chk("both_en_rdata", rdata0,      32'hA5A5A5A5);
    req(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    chk("both_en_nowrite", rdata0,    32'h00008000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
